// File: rtl/vconv_mode_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vconv_mode_ctrl_pkg
// Shared definitions for the colour-space mode sequencer:
//   - state_t     : FSM state encoding (ST_STABLE, ST_WAIT_VS, ST_BLANK, ST_SETTLE)
//   - mode_t      : {c709, ypbpr} mode pair used for target/pending/applied
//   - VSYNC_N_IDX : bit position of nVSYNC inside the video sync slice S[]
//   - TIMEOUT_CYC_DEFAULT : default VCLK cycles to wait for nVSYNC
//   - cnt_width() : counter width helper, never returns less than 1 bit
// ---------------------------------------------------------------------------
package vconv_mode_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_STABLE  = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_BLANK   = 2'd2,
      ST_SETTLE  = 2'd3
   } state_t;

   typedef struct packed {
      logic c709;
      logic ypbpr;
   } mode_t;

   localparam int VSYNC_N_IDX         = 3;
   localparam int TIMEOUT_CYC_DEFAULT = 2000000;

   // A counter that only has to reach n-1 needs $clog2(n) bits; a count
   // limit of 1 still gets a 1-bit register so no zero-width vectors appear.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vconv_mode_ctrl_vsync_fall_det.sv
// ---------------------------------------------------------------------------
// vconv_mode_ctrl_vsync_fall_det
// Frame-boundary detector: remembers the last nVSYNC value seen on a valid
// video sample and flags a falling edge on the current valid sample.
//   clk     in  video clock (VCLK)
//   rst     in  synchronous active-high reset
//   valid   in  video sample valid; invalid cycles are invisible to the edge
//   vsync_n in  nVSYNC bit of the current sample
//   fall    out combinational pulse: valid & previous-high & current-low
// ---------------------------------------------------------------------------
module vconv_mode_ctrl_vsync_fall_det (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   input  logic vsync_n,
   output logic fall
);

   logic vs_prev;

   // Resets high so a stream that starts with nVSYNC low counts as a boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev <= 1'b1;
      end else if (valid) begin
         vs_prev <= vsync_n;
      end
   end

   assign fall = valid & vs_prev & ~vsync_n;

endmodule

// File: rtl/vconv_mode_ctrl.sv
// ---------------------------------------------------------------------------
// vconv_mode_ctrl
// Sequences the RGB->YPbPr stage mode (nEN_YPbPr) and, when the
// VCONV_COEF709_EN macro is defined, the coefficient-set select. A requested
// change is applied only at a frame boundary (nVSYNC falling on a valid
// sample), after which the output is held black for BLANK_FRAMES frames plus
// PIPE_LAT cycles. With no video, the change is applied unblanked after
// TIMEOUT_CYC cycles.
//
// Parameters:
//   BLANK_FRAMES (1..15) frames blanked after a switch
//   PIPE_LAT     (1..15) conversion-pipeline latency covered after blanking
//   TIMEOUT_CYC          cycles to wait for nVSYNC before applying unblanked
//
// Ports:
//   VCLK          in  video clock
//   RST           in  synchronous active-high reset
//   vdata_valid_i in  video sample valid
//   vsync_n_i     in  nVSYNC bit of the sync slice, used only when valid
//   ypbpr_req_i   in  requested mode (1 = YPbPr), asynchronous
//   c709_req_i    in  requested coefficient set (1 = Rec.709), asynchronous
//   nEN_YPbPr     out conversion enable, active-low
//   coef_sel_o    out coefficient set select
//   blank_o       out force-black request
//   busy_o        out high whenever the FSM is not in ST_STABLE
//
// Video handshake: the stream is valid-only (no back-pressure); a sample
// exists on a cycle exactly when vdata_valid_i is high, and vsync_n_i is
// ignored on every other cycle.
//
// Build option: define VCONV_COEF709_EN to let c709_req_i take part in
// sequencing; otherwise it is ignored and coef_sel_o stays 0.
// ---------------------------------------------------------------------------
module vconv_mode_ctrl
   import vconv_mode_ctrl_pkg::*;
#(
   parameter int BLANK_FRAMES = 2,
   parameter int PIPE_LAT     = 4,
   parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEFAULT
) (
   input  logic VCLK,
   input  logic RST,
   input  logic vdata_valid_i,
   input  logic vsync_n_i,
   input  logic ypbpr_req_i,
   input  logic c709_req_i,
   output logic nEN_YPbPr,
   output logic coef_sel_o,
   output logic blank_o,
   output logic busy_o
);

   localparam int FW = cnt_width(BLANK_FRAMES);
   localparam int LW = cnt_width(PIPE_LAT);
   localparam int TW = cnt_width(TIMEOUT_CYC);

   localparam logic [FW-1:0] FRAME_LAST = FW'(BLANK_FRAMES - 1);
   localparam logic [LW-1:0] LAT_LAST   = LW'(PIPE_LAT - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

   // ------------------------------------------------------------------
   // Request synchronisers (bit 1 is the synchronised output)
   // ------------------------------------------------------------------
   logic [1:0] ypbpr_sync;
   mode_t      target;

   always_ff @(posedge VCLK) begin
      if (RST) begin
         ypbpr_sync <= 2'b00;
      end else begin
         ypbpr_sync <= {ypbpr_sync[0], ypbpr_req_i};
      end
   end

`ifdef VCONV_COEF709_EN
   logic [1:0] c709_sync;

   always_ff @(posedge VCLK) begin
      if (RST) begin
         c709_sync <= 2'b00;
      end else begin
         c709_sync <= {c709_sync[0], c709_req_i};
      end
   end

   assign target.c709  = c709_sync[1];
`else
   logic unused_c709;
   assign unused_c709  = c709_req_i;
   assign target.c709  = 1'b0;
`endif
   assign target.ypbpr = ypbpr_sync[1];

   // ------------------------------------------------------------------
   // Frame boundary
   // ------------------------------------------------------------------
   logic vs_fall;

   vconv_mode_ctrl_vsync_fall_det u_vs_det (
      .clk     (VCLK),
      .rst     (RST),
      .valid   (vdata_valid_i),
      .vsync_n (vsync_n_i),
      .fall    (vs_fall)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   state_t        state,     state_nxt;
   mode_t         applied,   applied_nxt;
   mode_t         pending,   pending_nxt;
   logic [FW-1:0] frame_cnt, frame_nxt;
   logic [LW-1:0] lat_cnt,   lat_nxt;
   logic [TW-1:0] tmo_cnt,   tmo_nxt;
   logic          blank_nxt;

   always_comb begin
      state_nxt   = state;
      applied_nxt = applied;
      pending_nxt = pending;
      frame_nxt   = frame_cnt;
      lat_nxt     = lat_cnt;
      tmo_nxt     = tmo_cnt;
      blank_nxt   = blank_o;

      case (state)
         ST_STABLE: begin
            if (target != applied) begin
               pending_nxt = target;
               tmo_nxt     = '0;
               state_nxt   = ST_WAIT_VS;
            end
         end

         ST_WAIT_VS: begin
            pending_nxt = target;
            tmo_nxt     = tmo_cnt + TW'(1);
            if (target == applied) begin
               // Request withdrawn before any boundary: nothing to do.
               state_nxt = ST_STABLE;
            end else if (vs_fall) begin
               // A boundary beats a timeout on the same cycle.
               applied_nxt = pending;
               blank_nxt   = 1'b1;
               frame_nxt   = '0;
               state_nxt   = ST_BLANK;
            end else if (tmo_cnt == TMO_LAST) begin
               // No video present: apply without blanking, still wait out
               // the pipeline latency before reporting idle.
               applied_nxt = pending;
               blank_nxt   = 1'b0;
               lat_nxt     = '0;
               state_nxt   = ST_SETTLE;
            end
         end

         ST_BLANK: begin
            if (vs_fall) begin
               if (frame_cnt == FRAME_LAST) begin
                  lat_nxt   = '0;
                  state_nxt = ST_SETTLE;
               end else begin
                  frame_nxt = frame_cnt + FW'(1);
               end
            end
         end

         ST_SETTLE: begin
            if (lat_cnt == LAT_LAST) begin
               blank_nxt = 1'b0;
               state_nxt = ST_STABLE;
            end else begin
               lat_nxt = lat_cnt + LW'(1);
            end
         end

         default: begin
            state_nxt = ST_STABLE;
         end
      endcase
   end

   // Outputs are loaded from the next-state values so they change on the
   // same edge as the state/applied registers.
   always_ff @(posedge VCLK) begin
      if (RST) begin
         state      <= ST_STABLE;
         applied    <= '0;
         pending    <= '0;
         frame_cnt  <= '0;
         lat_cnt    <= '0;
         tmo_cnt    <= '0;
         blank_o    <= 1'b0;
         busy_o     <= 1'b0;
         nEN_YPbPr  <= 1'b1;
         coef_sel_o <= 1'b0;
      end else begin
         state      <= state_nxt;
         applied    <= applied_nxt;
         pending    <= pending_nxt;
         frame_cnt  <= frame_nxt;
         lat_cnt    <= lat_nxt;
         tmo_cnt    <= tmo_nxt;
         blank_o    <= blank_nxt;
         busy_o     <= (state_nxt != ST_STABLE);
         nEN_YPbPr  <= ~applied_nxt.ypbpr;
         coef_sel_o <= applied_nxt.c709;
      end
   end

endmodule

// File: tb/tb_vconv_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vconv_mode_ctrl
// Self-checking bench for vconv_mode_ctrl (BLANK_FRAMES=2, PIPE_LAT=4,
// TIMEOUT_CYC=100). Output changes of {nEN_YPbPr, coef_sel_o, blank_o,
// busy_o} are matched against an expected queue of {cycle, value} entries
// pushed by the stimulus as it drives requests and frame boundaries.
// Build option VCONV_COEF709_EN selects the coefficient-switch scenario.
// ---------------------------------------------------------------------------
module tb_vconv_mode_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic valid;
   logic vsync_n;
   logic ypbpr_req;
   logic c709_req;
   logic nen;
   logic coef_sel;
   logic blank;
   logic busy;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   vconv_mode_ctrl #(
      .BLANK_FRAMES (2),
      .PIPE_LAT     (4),
      .TIMEOUT_CYC  (100)
   ) dut (
      .VCLK          (clk),
      .RST           (rst),
      .vdata_valid_i (valid),
      .vsync_n_i     (vsync_n),
      .ypbpr_req_i   (ypbpr_req),
      .c709_req_i    (c709_req),
      .nEN_YPbPr     (nen),
      .coef_sel_o    (coef_sel),
      .blank_o       (blank),
      .busy_o        (busy)
   );

   // ---------------- scoreboard ----------------
   // entry = {cycle[31:0], nen, coef, blank, busy}
   logic [35:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        mon_en   = 1'b0;
   logic [3:0]  prev     = 4'b1000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, got, got, exp, exp, cyc);
      end
   endtask

   function automatic logic [35:0] mk(input int c, input logic [3:0] v);
      logic [31:0] cw;
      cw = c;
      return {cw, v};
   endfunction

   always @(negedge clk) begin
      logic [3:0]  cur;
      logic [35:0] e;
      if (mon_en) begin
         cur = {nen, coef_sel, blank, busy};
         if (cur !== prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_change", {28'd0, cur}, {28'd0, prev});
            end else begin
               e = exp_q.pop_front();
               check("evt_value", {28'd0, cur}, {28'd0, e[3:0]});
               check("evt_cycle", cyc, e[35:4]);
            end
            prev = cur;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_idle();
      valid   = ($urandom_range(0, 3) != 0);
      vsync_n = 1'b1;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick_idle();
   endtask

   // Advance until n valid samples have gone by with nVSYNC high.
   task automatic frame(input int n);
      int seen;
      seen = 0;
      while (seen < n) begin
         valid   = ($urandom_range(0, 3) != 0);
         vsync_n = 1'b1;
         if (valid) seen++;
         tick();
      end
   endtask

   // nVSYNC goes low first on invalid samples (must not count), then on a
   // valid sample, which is the boundary seen at edge f+1. When push_en is
   // set, value v is expected at edge f+1+delay.
   task automatic do_fall(input logic push_en, input logic [3:0] v, input int delay,
                          output int f);
      vsync_n = 1'b0;
      valid   = 1'b0;
      tick();
      tick();
      valid = 1'b1;
      f     = cyc;
      if (push_en) exp_q.push_back(mk(f + 1 + delay, v));
      tick();
      for (int i = 0; i < 3; i++) begin
         valid = ($urandom_range(0, 1) != 0);
         tick();
      end
      vsync_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick_idle();
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // A request (or reset release) was driven at the current cycle: busy at
   // +3, blank and new mode at first boundary +1, idle 4 cycles after the
   // second following boundary.
   task automatic vs_sequence(input string tag, input logic [3:0] busy_v,
                              input logic [3:0] blank_v, input logic [3:0] done_v);
      int f;
      exp_q.push_back(mk(cyc + 3, busy_v));
      idle(20);
      do_fall(1'b1, blank_v, 0, f);
      frame(1000);
      do_fall(1'b0, 4'b0000, 0, f);
      frame(1000);
      do_fall(1'b1, done_v, 4, f);
      idle(20);
      drain(tag);
   endtask

   // No video: change applied unblanked 100 cycles into WAIT_VS, idle 4 later.
   task automatic timeout_switch(input string tag, input logic req);
      int n;
      ypbpr_req = req;
      n = cyc;
      exp_q.push_back(mk(n + 3,   {req, 3'b001}));
      exp_q.push_back(mk(n + 103, {~req, 3'b001}));
      exp_q.push_back(mk(n + 107, {~req, 3'b000}));
      idle(150);
      drain(tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int f;
      int r;
      rst       = 1'b1;
      valid     = 1'b0;
      vsync_n   = 1'b1;
      ypbpr_req = 1'b0;
      c709_req  = 1'b0;
      repeat (3) tick();

      check("rst_nen",   {31'd0, nen},      32'd1);
      check("rst_coef",  {31'd0, coef_sel}, 32'd0);
      check("rst_blank", {31'd0, blank},    32'd0);
      check("rst_busy",  {31'd0, busy},     32'd0);
      prev   = 4'b1000;
      mon_en = 1'b1;

      // Power-up with YPbPr requested.
      ypbpr_req = 1'b1;
      idle(2);
      rst = 1'b0;
      vs_sequence("drain_powerup", 4'b1001, 4'b0011, 4'b0000);

      // Request withdrawn inside WAIT_VS: busy pulse only.
      ypbpr_req = 1'b0;
      exp_q.push_back(mk(cyc + 3, 4'b0001));
      idle(20);
      ypbpr_req = 1'b1;
      exp_q.push_back(mk(cyc + 3, 4'b0000));
      idle(20);
      drain("drain_withdraw");

      // Timeout path both ways, no video boundaries.
      timeout_switch("drain_timeout_rgb", 1'b0);
      timeout_switch("drain_timeout_ypbpr", 1'b1);

      // Change requested during BLANK: deferred, busy drops for one cycle.
      ypbpr_req = 1'b0;
      exp_q.push_back(mk(cyc + 3, 4'b0001));
      idle(20);
      do_fall(1'b1, 4'b1011, 0, f);
      idle(30);
      ypbpr_req = 1'b1;
      frame(1000);
      do_fall(1'b0, 4'b0000, 0, f);
      frame(1000);
      do_fall(1'b1, 4'b1000, 4, f);
      exp_q.push_back(mk(f + 6, 4'b1001));
      idle(20);
      do_fall(1'b1, 4'b0011, 0, f);
      frame(1000);
      do_fall(1'b0, 4'b0000, 0, f);
      frame(1000);
      do_fall(1'b1, 4'b0000, 4, f);
      idle(20);
      drain("drain_blank_change");

      // Reset pulse mid-BLANK, then the held request is served again.
      timeout_switch("drain_pre_reset", 1'b0);
      ypbpr_req = 1'b1;
      exp_q.push_back(mk(cyc + 3, 4'b1001));
      idle(20);
      do_fall(1'b1, 4'b0011, 0, f);
      idle(50);
      rst = 1'b1;
      r   = cyc;
      exp_q.push_back(mk(r + 1, 4'b1000));
      tick_idle();
      rst = 1'b0;
      vs_sequence("drain_after_reset", 4'b1001, 4'b0011, 4'b0000);

      // Coefficient-set request alone.
      c709_req = 1'b1;
`ifdef VCONV_COEF709_EN
      vs_sequence("drain_coef709", 4'b0001, 4'b0111, 4'b0100);
      check("coef_final", {31'd0, coef_sel}, 32'd1);
`else
      idle(50);
      do_fall(1'b0, 4'b0000, 0, f);
      idle(50);
      drain("drain_coef_ignored");
      check("coef_final", {31'd0, coef_sel}, 32'd0);
      check("busy_final", {31'd0, busy},     32'd0);
`endif
      check("nen_final", {31'd0, nen}, 32'd0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
